// File: rtl/hcount_gen.sv
// Horizontal pixel counter with half-line toggle, registered blank/sync levels,
// line/half-line tick pulses and a sticky wrap-without-period-match flag.
module hcount_gen (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        cnten,
  input  logic        cntwr,
  input  logic [10:0] din,
  input  logic        hp_eq,
  input  logic        hbb_eq,
  input  logic        hbe_eq,
  input  logic        hs_eq,
  input  logic        hse_eq,
  output logic [10:0] count,
  output logic        hblank,
  output logic        hsync,
  output logic        line_tick,
  output logic        half_tick,
  output logic        ovf
);

  localparam int unsigned CW = 11;
  localparam int unsigned PW = 10;

  logic [CW-1:0] count_q, count_d;
  logic          hblank_q, hblank_d;
  logic          hsync_q, hsync_d;
  logic          line_tick_q, line_tick_d;
  logic          half_tick_q, half_tick_d;
  logic          ovf_q, ovf_d;

  // Next-state: preload beats counting; compares only act on enabled ticks.
  always_comb begin
    count_d     = count_q;
    hblank_d    = hblank_q;
    hsync_d     = hsync_q;
    line_tick_d = 1'b0;
    half_tick_d = 1'b0;
    ovf_d       = ovf_q;

    if (cntwr) begin
      count_d = din;
      ovf_d   = 1'b0;
    end else if (cnten) begin
      if (hp_eq) begin
        count_d     = {~count_q[CW-1], PW'(0)};
        half_tick_d = 1'b1;
        line_tick_d = count_q[CW-1];
      end else if (&count_q[PW-1:0]) begin
        count_d = {count_q[CW-1], PW'(0)};
        ovf_d   = 1'b1;
      end else begin
        count_d = {count_q[CW-1], count_q[PW-1:0] + PW'(1)};
      end

      if (hbb_eq) begin
        hblank_d = 1'b1;
      end else if (hbe_eq) begin
        hblank_d = 1'b0;
      end

      if (hse_eq) begin
        hsync_d = 1'b0;
      end else if (hs_eq) begin
        hsync_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      count_q     <= CW'(0);
      hblank_q    <= 1'b1;
      hsync_q     <= 1'b0;
      line_tick_q <= 1'b0;
      half_tick_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      hblank_q    <= hblank_d;
      hsync_q     <= hsync_d;
      line_tick_q <= line_tick_d;
      half_tick_q <= half_tick_d;
      ovf_q       <= ovf_d;
    end
  end

  assign count     = count_q;
  assign hblank    = hblank_q;
  assign hsync     = hsync_q;
  assign line_tick = line_tick_q;
  assign half_tick = half_tick_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_hcount_gen.sv
// Directed bench for hcount_gen; compare inputs are modelled from the live count.
module tb_hcount_gen;

  logic        sys_clk = 1'b0;
  logic        reset, cnten, cntwr;
  logic [10:0] din;
  logic        hp_eq, hbb_eq, hbe_eq, hs_eq, hse_eq;
  logic [10:0] count;
  logic        hblank, hsync, line_tick, half_tick, ovf;

  logic per_en, cmp_en;
  logic hp_frc, hbb_frc, hbe_frc, hs_frc, hse_frc;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  // Compare registers: period 9, blank 7..0x402, sync 3..5, plus direct overrides.
  assign hp_eq  = (per_en && count[9:0] == 10'd9) || hp_frc;
  assign hbb_eq = (cmp_en && count == 11'h007) || hbb_frc;
  assign hbe_eq = (cmp_en && count == 11'h402) || hbe_frc;
  assign hs_eq  = (cmp_en && count == 11'h003) || hs_frc;
  assign hse_eq = (cmp_en && count == 11'h005) || hse_frc;

  hcount_gen dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .cnten     (cnten),
    .cntwr     (cntwr),
    .din       (din),
    .hp_eq     (hp_eq),
    .hbb_eq    (hbb_eq),
    .hbe_eq    (hbe_eq),
    .hs_eq     (hs_eq),
    .hse_eq    (hse_eq),
    .count     (count),
    .hblank    (hblank),
    .hsync     (hsync),
    .line_tick (line_tick),
    .half_tick (half_tick),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_ticks(input string tag, input logic half_exp, input logic line_exp);
    check({tag, "_half"}, 32'(half_tick), 32'(half_exp));
    check({tag, "_line"}, 32'(line_tick), 32'(line_exp));
  endtask

  initial begin
    logic [10:0] exp_cnt;
    logic [10:0] wrap_seq [4];
    wrap_seq[0] = 11'h3fd; wrap_seq[1] = 11'h3fe; wrap_seq[2] = 11'h3ff; wrap_seq[3] = 11'h000;

    reset = 1'b1; cnten = 1'b0; cntwr = 1'b0; din = '0;
    per_en = 1'b0; cmp_en = 1'b0;
    hp_frc = 1'b0; hbb_frc = 1'b0; hbe_frc = 1'b0; hs_frc = 1'b0; hse_frc = 1'b0;

    // Reset values before any clock edge
    #2;
    check("rst_count", 32'(count), 32'h0);
    check("rst_hblank", 32'(hblank), 32'h1);
    check("rst_hsync", 32'(hsync), 32'h0);
    check_ticks("rst", 1'b0, 1'b0);
    check("rst_ovf", 32'(ovf), 32'h0);
    step();
    reset = 1'b0;

    // Period 9, continuous enable, blank/sync compares active
    per_en = 1'b1; cmp_en = 1'b1; cnten = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_cnt = 11'(k % 10) | (((k / 10) % 2) != 0 ? 11'h400 : 11'h000);
      check($sformatf("per_cnt_%0d", k), 32'(count), 32'(exp_cnt));
      check_ticks($sformatf("per_%0d", k), (k % 10) == 0, (k % 20) == 0);
      check($sformatf("per_hblank_%0d", k), 32'(hblank), 32'(k <= 12 || k >= 28));
      check($sformatf("per_hsync_%0d", k), 32'(hsync), 32'((k % 20) == 4 || (k % 20) == 5));
    end

    // Forced compares: begin wins for blank, end wins for sync
    per_en = 1'b0; cmp_en = 1'b0;
    hbe_frc = 1'b1; hs_frc = 1'b1;
    step();
    check("frc1_hblank", 32'(hblank), 32'h0);
    check("frc1_hsync", 32'(hsync), 32'h1);
    check("frc1_cnt", 32'(count), 32'h401);
    hbb_frc = 1'b1; hse_frc = 1'b1;
    step();
    check("frc2_hblank", 32'(hblank), 32'h1);
    check("frc2_hsync", 32'(hsync), 32'h0);
    hbb_frc = 1'b0; hbe_frc = 1'b0; hs_frc = 1'b0; hse_frc = 1'b0;

    // cnten toggling 1,0,0,1 with period match at 9
    cnten = 1'b0; cntwr = 1'b1; din = 11'h009;
    step();
    check("tog_load", 32'(count), 32'h009);
    check("tog_load_hblank", 32'(hblank), 32'h1);
    cntwr = 1'b0; per_en = 1'b1; cnten = 1'b1;
    step();
    check("tog1_cnt", 32'(count), 32'h400);
    check_ticks("tog1", 1'b1, 1'b0);
    cnten = 1'b0;
    step();
    check("tog2_cnt", 32'(count), 32'h400);
    check_ticks("tog2", 1'b0, 1'b0);
    step();
    check("tog3_cnt", 32'(count), 32'h400);
    check_ticks("tog3", 1'b0, 1'b0);
    cnten = 1'b1;
    step();
    check("tog4_cnt", 32'(count), 32'h401);
    check_ticks("tog4", 1'b0, 1'b0);

    // Wrap without period match sets sticky ovf; preload clears it
    per_en = 1'b0; cnten = 1'b0; cntwr = 1'b1; din = 11'h3fc;
    step();
    check("wrap_load", 32'(count), 32'h3fc);
    cntwr = 1'b0; cnten = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("wrap_cnt_%0d", i), 32'(count), 32'(wrap_seq[i]));
      check($sformatf("wrap_ovf_%0d", i), 32'(ovf), 32'(i == 3));
      check_ticks($sformatf("wrap_%0d", i), 1'b0, 1'b0);
    end
    step();
    check("wrap_after_cnt", 32'(count), 32'h001);
    check("wrap_after_ovf", 32'(ovf), 32'h1);
    cntwr = 1'b1; din = 11'h005;
    step();
    check("wrap_clr_cnt", 32'(count), 32'h005);
    check("wrap_clr_ovf", 32'(ovf), 32'h0);

    // Full line end from second half; tick lasts one cycle
    per_en = 1'b1; cnten = 1'b0; cntwr = 1'b1; din = 11'h409;
    step();
    cntwr = 1'b0; cnten = 1'b1;
    step();
    check("line_cnt", 32'(count), 32'h000);
    check_ticks("line", 1'b1, 1'b1);
    step();
    check("line_next_cnt", 32'(count), 32'h001);
    check_ticks("line_next", 1'b0, 1'b0);

    // Preload together with enable and period match: load wins, no tick
    cntwr = 1'b1; din = 11'h123; hp_frc = 1'b1;
    step();
    check("pre_cnt", 32'(count), 32'h123);
    check_ticks("pre", 1'b0, 1'b0);
    hp_frc = 1'b0; din = 11'h409;
    step();
    din = 11'h0aa;
    step();
    check("pre2_cnt", 32'(count), 32'h0aa);
    check_ticks("pre2", 1'b0, 1'b0);

    // Async reset mid-line with hsync high
    per_en = 1'b0; cntwr = 1'b0; cnten = 1'b1; hs_frc = 1'b1;
    step();
    check("ar_hsync_set", 32'(hsync), 32'h1);
    hs_frc = 1'b0; cnten = 1'b0; cntwr = 1'b1; din = 11'h204;
    step();
    check("ar_load", 32'(count), 32'h204);
    check("ar_hsync_hold", 32'(hsync), 32'h1);
    cntwr = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("ar_count", 32'(count), 32'h0);
    check("ar_hblank", 32'(hblank), 32'h1);
    check("ar_hsync", 32'(hsync), 32'h0);
    check("ar_ovf", 32'(ovf), 32'h0);
    check_ticks("ar", 1'b0, 1'b0);
    cntwr = 1'b1; cnten = 1'b1; din = 11'h077;
    step();
    check("ar_hold_cnt", 32'(count), 32'h0);
    cntwr = 1'b0; reset = 1'b0;
    check("ar_rel_cnt", 32'(count), 32'h0);
    step();
    check("ar_run1", 32'(count), 32'h1);
    step();
    check("ar_run2", 32'(count), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hcount_gen.md
HCOUNT_GEN -- requirements
Module: hcount_gen

Interface
REQ-001 sys_clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 cnten  input  1  count enable tick (one pixel period); counting and compare sampling occur only when high.
REQ-004 cntwr  input  1  CPU preload strobe for count; sampled at the clock edge.
REQ-005 din  input  11  preload value for count.
REQ-006 hp_eq  input  1  period-compare equality: count[9:0] equals programmed period.
REQ-007 hbb_eq  input  1  blank-begin compare equality.
REQ-008 hbe_eq  input  1  blank-end compare equality.
REQ-009 hs_eq  input  1  sync-start compare equality.
REQ-010 hse_eq  input  1  sync-end compare equality.
REQ-011 count  output  11  horizontal count; bit 10 = half-line flag, bits 9:0 = position; drives the compare registers.
REQ-012 hblank  output  1  registered blanking level.
REQ-013 hsync  output  1  registered sync level.
REQ-014 line_tick  output  1  one-cycle pulse at end of each full line.
REQ-015 half_tick  output  1  one-cycle pulse at end of each half line.
REQ-016 ovf  output  1  sticky flag: count[9:0] wrapped without a period match.

Function
REQ-017 All *_eq inputs SHALL be treated as combinational functions of the current count; the block SHALL add no input registering.
REQ-018 cntwr=1 SHALL load count<=din, clear ovf, and suppress counting and tick generation that cycle; hblank/hsync SHALL hold.
REQ-019 cnten=0 and cntwr=0 SHALL hold all state; line_tick and half_tick SHALL be 0.
REQ-020 cnten=1, hp_eq=1: count[9:0]<=0, count[10]<=~count[10], half_tick=1 next cycle.
REQ-021 Same event with count[10]=1 SHALL also assert line_tick next cycle (full line = two half lines).
REQ-022 cnten=1, hp_eq=0, count[9:0]!=1023: count[9:0] increments by 1, bit 10 unchanged.
REQ-023 cnten=1, hp_eq=0, count[9:0]=1023: count[9:0]<=0, bit 10 unchanged, ovf<=1, no ticks.
REQ-024 hblank: with cnten=1, set on hbb_eq, clear on hbe_eq; both asserted -> hblank<=1 (begin wins).
REQ-025 hsync: with cnten=1, set on hs_eq, clear on hse_eq; both asserted -> hsync<=0 (end wins).
REQ-026 Output latency: hblank/hsync/ticks change one clock after the sampling edge where the qualifying compare was high.
REQ-027 Ticks SHALL be single-cycle regardless of how long cnten stays high on the following cycle.
REQ-028 hp_eq coincident with hbb_eq/hs_eq SHALL apply all effects in the same cycle, independently.
REQ-029 ovf SHALL remain set until cntwr or reset; counting continues normally after overflow.

Reset
REQ-030 reset=1 SHALL immediately force count=0, hblank=1, hsync=0, line_tick=0, half_tick=0, ovf=0, regardless of sys_clk.
REQ-031 Reset asserted mid-line SHALL abort the line; after release, counting resumes from 0 on the first cnten edge.
REQ-032 cntwr or cnten asserted during reset SHALL have no effect.

Verification
REQ-033 Period 9 model (hp_eq when count[9:0]=9), cnten=1 continuous: count 0..9, 0x400..0x409, 0; half_tick after each 9, line_tick only after 0x409.
REQ-034 Blank model hbb at 7, hbe at 2: hblank rises cycle after count=7, falls cycle after count=0x402; hbb_eq/hbe_eq forced together -> hblank=1.
REQ-035 cnten toggling 1,0,0,1 with hp_eq held at count=9: single half_tick, count advances only on cnten=1 edges.
REQ-036 No period match, count preloaded 1020: after 4 enabled edges count=0, ovf=1, no ticks; cntwr din=0x005 -> count=0x005, ovf=0.
REQ-037 cntwr and cnten with hp_eq in same cycle: count=din, no tick, no toggle.
REQ-038 Reset asserted asynchronously at count=0x204 with hsync=1: outputs reset values before next edge; after release count 0,1,2 on enabled edges.
